// File: rtl/fan_adc_conditioner_pkg.sv
// Shared definitions for the fan ADC input conditioner.
// FSM encoding, default widths and the rounding helper.
package fan_adc_conditioner_pkg;

    localparam int ADC_BITWIDTH_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fan_state_e;

    // Half an LSB of the shifted result, so the shift rounds to nearest
    function automatic int round_bias(input int log2);
        return (log2 == 0) ? 0 : (1 << (log2 - 1));
    endfunction

endpackage

// File: rtl/fan_adc_conditioner_if.sv
// Filtered-sample bundle handed to the fan controller.
// Master drives the averaged value, its strobe and window status.
interface fan_adc_conditioner_if #(
    parameter int ADC_BITWIDTH = 4
);
    logic [ADC_BITWIDTH-1:0] adc_avg_o;
    logic                    adc_valid_o;
    logic                    filled_o;

    modport master (
        output adc_avg_o,
        output adc_valid_o,
        output filled_o
    );

    modport slave (
        input adc_avg_o,
        input adc_valid_o,
        input filled_o
    );
endinterface

// File: rtl/fan_adc_conditioner_prescaler.sv
// Sample prescaler: one strobe every period+1 enabled cycles.
// A period lowered below the count wraps through all-ones to zero.
module fan_sample_prescaler #(
    parameter int DIV_BITWIDTH = 20
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic [DIV_BITWIDTH-1:0] sample_period_i,
    output logic                    strobe
);
    logic [DIV_BITWIDTH-1:0] cnt_q;
    logic                    hit;

    assign hit    = (cnt_q == sample_period_i);
    assign strobe = clk_en_i && hit;

    // Free-running counter, restarts on terminal count
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clk_en_i) begin
            cnt_q <= hit ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/fan_adc_conditioner.sv
// Temperature ADC input stage: synchronise, decimate, average.
// Emits a rounded moving average plus a one-cycle valid strobe.
module fan_adc_conditioner
    import fan_adc_conditioner_pkg::*;
#(
    parameter int ADC_BITWIDTH = ADC_BITWIDTH_DEF,
    parameter int AVG_LOG2     = 2,
    parameter int DIV_BITWIDTH = 20
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic [ADC_BITWIDTH-1:0] adc_raw_i,
    input  logic [DIV_BITWIDTH-1:0] sample_period_i,
    input  logic                    flush_i,
    fan_adc_conditioner_if.master   out_if
);
    localparam int D  = 1 << AVG_LOG2;
    localparam int SW = ADC_BITWIDTH + AVG_LOG2;
    localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SW-1:0] BIAS = SW'(round_bias(AVG_LOG2));

    logic [ADC_BITWIDTH-1:0] sync1_q;
    logic [ADC_BITWIDTH-1:0] sync2_q;
    logic [ADC_BITWIDTH-1:0] win_q [D];
    logic [SW-1:0]           sum_q;
    logic [SW-1:0]           sum_next;
    logic [SW-1:0]           sum_rnd;
    logic [ADC_BITWIDTH-1:0] avg_next;
    logic [ADC_BITWIDTH-1:0] avg_q;
    logic                    valid_q;
    logic [FW-1:0]           fill_q;
    logic [FW-1:0]           fill_d;
    fan_state_e              state_q;
    fan_state_e              state_d;
    logic                    strobe;
    logic                    flush_en;
    logic                    take;
    logic                    fill_done;
    logic                    publish;

    fan_sample_prescaler #(
        .DIV_BITWIDTH(DIV_BITWIDTH)
    ) u_prescaler (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .clk_en_i       (clk_en_i),
        .sample_period_i(sample_period_i),
        .strobe         (strobe)
    );

    // A flush discards any sample arriving in the same cycle
    assign flush_en  = clk_en_i && flush_i;
    assign take      = strobe && !flush_i;
    assign fill_done = (fill_q == FW'(D - 1));
    assign publish   = take && ((state_q == RUN) || fill_done);

    assign sum_next = sum_q + SW'(sync2_q) - SW'(win_q[D-1]);
    assign sum_rnd  = sum_next + BIAS;
    assign avg_next = ADC_BITWIDTH'(sum_rnd >> AVG_LOG2);

    // Two-flop synchroniser, runs on every clock regardless of enable
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= adc_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Sample window and running sum
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < D; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (flush_en) begin
            for (int i = 0; i < D; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (take) begin
            for (int i = D - 1; i > 0; i--) win_q[i] <= win_q[i-1];
            win_q[0] <= sync2_q;
            sum_q    <= sum_next;
        end
    end

    // FSM next state and fill counter
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (flush_en) begin
            state_d = FILL;
            fill_d  = '0;
        end else if (take && state_q == FILL) begin
            if (fill_done) state_d = RUN;
            else           fill_d  = fill_q + 1'b1;
        end
    end

    // FSM state and fill counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Output value held between updates; valid is a single-cycle pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            avg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= publish;
            if (publish) avg_q <= avg_next;
        end
    end

    assign out_if.adc_avg_o   = avg_q;
    assign out_if.adc_valid_o = valid_q;
    assign out_if.filled_o    = (state_q == RUN);
endmodule

// File: tb/tb_fan_adc_conditioner.sv
// Scoreboard bench for the fan ADC conditioner.
// A cycle model queues expected averages; valid pulses pop them.
module tb_fan_adc_conditioner;
    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        en     = 1'b0;
    logic        flush  = 1'b0;
    logic [3:0]  raw    = 4'd0;
    logic [19:0] period = 20'd3;

    fan_adc_conditioner_if #(.ADC_BITWIDTH(4)) out_if ();

    fan_adc_conditioner dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .clk_en_i       (en),
        .adc_raw_i      (raw),
        .sample_period_i(period),
        .flush_i        (flush),
        .out_if         (out_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int seen_q[$];

    int m_s1, m_s2, m_cnt, m_fill, m_avg;
    int m_win[4];
    bit m_run;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_fill = 0; m_avg = 0; m_run = 0;
        for (int i = 0; i < 4; i++) m_win[i] = 0;
        exp_q.delete();
    endtask

    // Advance the reference model by one clock using current inputs
    task automatic model_step();
        bit stb;
        int sum;
        stb = en && (m_cnt == int'(period));
        if (en) m_cnt = stb ? 0 : m_cnt + 1;
        if (en && flush) begin
            for (int i = 0; i < 4; i++) m_win[i] = 0;
            m_fill = 0;
            m_run  = 0;
        end else if (stb) begin
            for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_s2;
            sum = m_win[0] + m_win[1] + m_win[2] + m_win[3];
            if (m_run || m_fill == 3) begin
                m_run = 1;
                m_avg = (sum + 2) / 4;
                exp_q.push_back(m_avg);
            end else begin
                m_fill++;
            end
        end
        m_s2 = m_s1;
        m_s1 = int'(raw);
    endtask

    task automatic tick();
        int e;
        model_step();
        @(posedge clk);
        #1;
        check("valid", 32'(out_if.adc_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("avg", 32'(out_if.adc_avg_o), 32'(e));
        end else begin
            check("hold", 32'(out_if.adc_avg_o), 32'(m_avg));
        end
        check("filled", 32'(out_if.filled_o), 32'(m_run));
        if (out_if.adc_valid_o) seen_q.push_back(int'(out_if.adc_avg_o));
    endtask

    task automatic run_until_valid(input int limit, output int n);
        bit got;
        got = 0;
        n = -1;
        for (int i = 1; i <= limit && !got; i++) begin
            tick();
            if (out_if.adc_valid_o) begin
                got = 1;
                n = i;
            end
        end
    endtask

    initial begin
        int n;
        int step_ref[4];
        step_ref[0] = 4; step_ref[1] = 8; step_ref[2] = 11; step_ref[3] = 15;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_avg", 32'(out_if.adc_avg_o), 32'd0);
        check("rst_valid", 32'(out_if.adc_valid_o), 32'd0);
        check("rst_filled", 32'(out_if.filled_o), 32'd0);

        // First window of constant 9s
        rstn = 1'b1;
        model_reset();
        en = 1'b1; period = 20'd3; raw = 4'd9;
        repeat (15) tick();
        check("t1_not_filled", 32'(out_if.filled_o), 32'd0);
        tick();
        check("t1_valid", 32'(out_if.adc_valid_o), 32'd1);
        check("t1_avg", 32'(out_if.adc_avg_o), 32'd9);
        check("t1_filled", 32'(out_if.filled_o), 32'd1);

        // Flush window to zeros, then step to 15
        raw = 4'd0;
        repeat (24) tick();
        seen_q.delete();
        raw = 4'd15;
        repeat (16) tick();
        check("t2_count", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check("t2_step", 32'(seen_q[i]), 32'(step_ref[i]));

        // Flush away from a strobe
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_filled", 32'(out_if.filled_o), 32'd0);
        check("t3_hold", 32'(out_if.adc_avg_o), 32'd15);
        run_until_valid(40, n);
        check("t3_latency", 32'(n), 32'd15);

        // Flush coinciding with a strobe
        for (int i = 0; i < 8 && m_cnt != 3; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_no_valid", 32'(out_if.adc_valid_o), 32'd0);
        run_until_valid(40, n);
        check("t4_latency", 32'(n), 32'd16);

        // Gated enable with strobe on every enabled cycle
        rstn = 1'b0;
        model_reset();
        #1;
        period = 20'd0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            en  = (i % 2) == 0;
            raw = 4'($urandom_range(15));
            tick();
        end

        // Async reset while a strobe is pending
        en = 1'b1;
        repeat (8) tick();
        check("t6_pre_filled", 32'(out_if.filled_o), 32'd1);
        rstn = 1'b0;
        model_reset();
        #1;
        check("t6_avg", 32'(out_if.adc_avg_o), 32'd0);
        check("t6_valid", 32'(out_if.adc_valid_o), 32'd0);
        check("t6_filled", 32'(out_if.filled_o), 32'd0);
        @(posedge clk);
        #1;
        check("t6_no_valid", 32'(out_if.adc_valid_o), 32'd0);
        check("t6_state", 32'(out_if.filled_o), 32'd0);
        rstn = 1'b1;
        raw = 4'd6;
        repeat (10) tick();
        check("t6_refill", 32'(out_if.filled_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
